imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage. Accepts a 32-bit RV instruction plus a sideband word (normally the PC) over a valid/ready handshake. Emits the correctly shifted, sign-extended XLEN-bit immediate, a format code and the sideband one cycle later. A 2-entry skid buffer gives full throughput under downstream backpressure. A synchronous flush supports branch redirects.

---
 rtl/imm_gen_pipe_pkg.sv | 35 +++
 rtl/imm_decode_comb.sv | 57 +++++
 rtl/imm_gen_pipe.sv | 118 +++++++++++
 tb/tb_imm_gen_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and opcode constants for the registered immediate generator.
// Build option: define IMM_CSR_ZIMM_EN to decode CSR immediate (zimm) forms.
package imm_gen_pipe_pkg;

    localparam int INSTR_W = 32;

    typedef logic [INSTR_W-1:0] data_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_ZIMM = 3'd6
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam logic [6:0] OP_I_TYPE   = 7'b0010011;
    localparam logic [6:0] OP_I_L_TYPE = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_S_TYPE   = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational RV immediate decode: instruction -> {XLEN-bit immediate, format}.
// Build option: IMM_CSR_ZIMM_EN enables the zimm decode of CSRR*I instructions.
module imm_decode_comb
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  data_t            i_instr,
    output logic [XLEN-1:0]  o_imm,
    output imm_type_e        o_type
);

    logic [31:0] val32;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        val32  = '0;
        o_type = IMM_NONE;
        case (i_instr[6:0])
            OP_I_TYPE, OP_I_L_TYPE, OP_JALR: begin
                val32  = {{20{i_instr[31]}}, i_instr[31:20]};
                o_type = IMM_I;
            end
            OP_S_TYPE: begin
                val32  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                o_type = IMM_S;
            end
            OP_B_TYPE: begin
                val32  = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
                o_type = IMM_B;
            end
            OP_LUI, OP_AUIPC: begin
                val32  = {i_instr[31:12], 12'b0};
                o_type = IMM_U;
            end
            OP_JAL: begin
                val32  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
                o_type = IMM_J;
            end
`ifdef IMM_CSR_ZIMM_EN
            OP_SYSTEM: begin
                if (i_instr[14]) begin
                    val32  = {27'b0, i_instr[19:15]};
                    o_type = IMM_ZIMM;
                end
            end
`endif
            default: ;
        endcase
    end

    // Bit 31 of every 32-bit form already equals the required extension bit, zimm included.
    assign o_imm = XLEN'($signed(val32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and synchronous flush.
// Build option: IMM_CSR_ZIMM_EN (passed through to imm_decode_comb).
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SB_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  data_t            i_Instruction,
    input  logic [SB_W-1:0]  i_Sideband,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_ExtendedImmediate,
    output imm_type_e        o_ImmType,
    output logic [SB_W-1:0]  o_Sideband
);

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .i_instr (i_Instruction),
        .o_imm   (dec_imm),
        .o_type  (dec_type)
    );

    skid_state_e     state_q, state_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    imm_type_e       out_type_q, out_type_d, skid_type_q, skid_type_d;
    logic [SB_W-1:0] out_sb_q, out_sb_d, skid_sb_q, skid_sb_d;

    logic accept, drain;

    // Ready depends only on the held state (and reset), never on i_ready.
    assign o_ready = i_rstn & (state_q != ST_TWO);
    assign o_valid = (state_q != ST_EMPTY);
    assign accept  = i_valid & o_ready;
    assign drain   = o_valid & i_ready;

    always_comb begin
        state_d     = state_q;
        out_imm_d   = out_imm_q;
        out_type_d  = out_type_q;
        out_sb_d    = out_sb_q;
        skid_imm_d  = skid_imm_q;
        skid_type_d = skid_type_q;
        skid_sb_d   = skid_sb_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_imm_d  = dec_imm;
                        out_type_d = dec_type;
                        out_sb_d   = i_Sideband;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_imm_d  = dec_imm;
                        out_type_d = dec_type;
                        out_sb_d   = i_Sideband;
                    end else if (accept) begin
                        skid_imm_d  = dec_imm;
                        skid_type_d = dec_type;
                        skid_sb_d   = i_Sideband;
                        state_d     = ST_TWO;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // o_ready is low here, so the only move is skid -> output.
                    if (drain) begin
                        out_imm_d  = skid_imm_q;
                        out_type_d = skid_type_q;
                        out_sb_d   = skid_sb_q;
                        state_d    = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // NOTE: the payload registers are cleared too, so outputs read as zero straight out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_EMPTY;
            out_imm_q   <= '0;
            out_type_q  <= IMM_NONE;
            out_sb_q    <= '0;
            skid_imm_q  <= '0;
            skid_type_q <= IMM_NONE;
            skid_sb_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_imm_q   <= out_imm_d;
            out_type_q  <= out_type_d;
            out_sb_q    <= out_sb_d;
            skid_imm_q  <= skid_imm_d;
            skid_type_q <= skid_type_d;
            skid_sb_q   <= skid_sb_d;
        end
    end

    assign o_ExtendedImmediate = out_imm_q;
    assign o_ImmType           = out_type_q;
    assign o_Sideband          = out_sb_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances driven in lockstep, expectations from a hand-built table.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, flush, valid, ready;
    logic [31:0] instr, sb;

    logic        o_ready32, o_valid32, o_ready64, o_valid64;
    logic [31:0] imm32, sb32, sb64;
    logic [63:0] imm64;
    imm_type_e   type32, type64;

    imm_gen_pipe #(.XLEN(32), .SB_W(32)) dut32 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(o_ready32),
        .i_Instruction(instr), .i_Sideband(sb), .o_valid(o_valid32), .i_ready(ready),
        .o_ExtendedImmediate(imm32), .o_ImmType(type32), .o_Sideband(sb32)
    );

    imm_gen_pipe #(.XLEN(64), .SB_W(32)) dut64 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(o_ready64),
        .i_Instruction(instr), .i_Sideband(sb), .o_valid(o_valid64), .i_ready(ready),
        .o_ExtendedImmediate(imm64), .o_ImmType(type64), .o_Sideband(sb64)
    );

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        imm_type_e   typ;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        imm_type_e   typ;
        logic [31:0] sb;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] sb_cnt = 32'h1000;

    logic        held_vld = 1'b0;
    logic [31:0] held_imm32, held_sb;
    logic [63:0] held_imm64;
    imm_type_e   held_typ;

    localparam int V_ADDI = 0, V_BEQ_M4 = 1, V_JAL_8 = 2, V_LUI = 3, V_CSRRWI = 4;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at the negedge, sample 4 time units later (1 before posedge).
    task automatic cycle(input logic v, input int idx, input logic r, input logic f);
        logic exp_rdy;
        exp_t e;
        valid = v;
        instr = vecs[idx].ins;
        ready = r;
        flush = f;
        sb    = sb_cnt;
        sb_cnt++;
        #4;
        if (!rstn) begin
            check("rst_ready32", 64'(o_ready32), 64'd0);
            check("rst_ready64", 64'(o_ready64), 64'd0);
            sbq.delete();
            held_vld = 1'b0;
        end else begin
            exp_rdy = (sbq.size() < 2);
            check("ready32", 64'(o_ready32), 64'(exp_rdy));
            check("ready64", 64'(o_ready64), 64'(exp_rdy));
            check("valid32", 64'(o_valid32), 64'(sbq.size() != 0));
            check("valid64", 64'(o_valid64), 64'(sbq.size() != 0));
            if (held_vld) begin
                check("hold_imm32", 64'(imm32), 64'(held_imm32));
                check("hold_imm64", imm64, held_imm64);
                check("hold_type", 64'(type32), 64'(held_typ));
                check("hold_sb", 64'(sb32), 64'(held_sb));
            end
            held_vld = 1'b0;
            if (sbq.size() != 0 && r) begin
                e = sbq.pop_front();
                check("imm32", 64'(imm32), 64'(e.imm[31:0]));
                check("imm64", imm64, e.imm);
                check("type32", 64'(type32), 64'(e.typ));
                check("type64", 64'(type64), 64'(e.typ));
                check("sb32", 64'(sb32), 64'(e.sb));
                check("sb64", 64'(sb64), 64'(e.sb));
            end else if (sbq.size() != 0 && !f) begin
                held_vld   = 1'b1;
                held_imm32 = imm32;
                held_imm64 = imm64;
                held_typ   = type32;
                held_sb    = sb32;
            end
            if (f) begin
                sbq.delete();
            end else if (v && exp_rdy) begin
                e.imm = vecs[idx].imm;
                e.typ = vecs[idx].typ;
                e.sb  = sb;
                sbq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; instr = '0; sb = '0;

        vecs.push_back('{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I});  // addi x1,x0,-1
        vecs.push_back('{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, IMM_B});  // beq -4
        vecs.push_back('{32'h0080006F, 64'h0000_0000_0000_0008, IMM_J});  // jal +8
        vecs.push_back('{32'h800000B7, 64'hFFFF_FFFF_8000_0000, IMM_U});  // lui 0x80000
`ifdef IMM_CSR_ZIMM_EN
        vecs.push_back('{32'h3401D073, 64'h0000_0000_0000_0003, IMM_ZIMM}); // csrrwi zimm=3
`else
        vecs.push_back('{32'h3401D073, 64'h0000_0000_0000_0000, IMM_NONE});
`endif
        vecs.push_back('{32'hFE112C23, 64'hFFFF_FFFF_FFFF_FFF8, IMM_S});  // sw -8
        vecs.push_back('{32'h7FF00093, 64'h0000_0000_0000_07FF, IMM_I});  // addi +2047
        vecs.push_back('{32'h12345097, 64'h0000_0000_1234_5000, IMM_U});  // auipc
        vecs.push_back('{32'hFFFFFFB3, 64'h0000_0000_0000_0000, IMM_NONE}); // OP, all ones
        vecs.push_back('{32'h01012083, 64'h0000_0000_0000_0010, IMM_I});  // lw +16
        vecs.push_back('{32'hFF0080E7, 64'hFFFF_FFFF_FFFF_FFF0, IMM_I});  // jalr -16
        vecs.push_back('{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, IMM_J});  // jal -4
        vecs.push_back('{32'h00000863, 64'h0000_0000_0000_0010, IMM_B});  // beq +16
        vecs.push_back('{32'h00100073, 64'h0000_0000_0000_0000, IMM_NONE}); // ebreak

        @(negedge clk);
        cycle(1'b1, V_ADDI, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        check("rst_valid", 64'(o_valid32), 64'd0);
        check("rst_imm32", 64'(imm32), 64'd0);
        check("rst_imm64", imm64, 64'd0);
        check("rst_type", 64'(type64), 64'(IMM_NONE));
        check("rst_sb", 64'(sb64), 64'd0);
        rstn = 1'b1;

        // single addi, then back-to-back beq/jal
        cycle(1'b1, V_ADDI, 1'b1, 1'b0);
        idle(2);
        cycle(1'b1, V_BEQ_M4, 1'b1, 1'b0);
        cycle(1'b1, V_JAL_8, 1'b1, 1'b0);
        idle(2);
        cycle(1'b1, V_LUI, 1'b1, 1'b0);
        cycle(1'b1, V_CSRRWI, 1'b1, 1'b0);
        idle(2);

        // backpressure: three offered, two accepted, drain in order
        cycle(1'b1, 5, 1'b0, 1'b0);
        cycle(1'b1, 6, 1'b0, 1'b0);
        cycle(1'b1, 7, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        idle(3);

        // flush in TWO with an input offered
        cycle(1'b1, 8, 1'b0, 1'b0);
        cycle(1'b1, 9, 1'b0, 1'b0);
        cycle(1'b1, 10, 1'b0, 1'b1);
        idle(3);

        // flush in ONE while draining: the draining entry still counts
        cycle(1'b1, 11, 1'b1, 1'b0);
        cycle(1'b1, 12, 1'b1, 1'b1);
        idle(2);

        for (int n = 0; n < 200; n++)
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, vecs.size() - 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        idle(3);

        // reset in the middle of a held pair
        cycle(1'b1, 1, 1'b0, 1'b0);
        cycle(1'b1, 2, 1'b0, 1'b0);
        rstn = 1'b0;
        cycle(1'b1, 3, 1'b1, 1'b0);
        rstn = 1'b1;
        idle(3);
        check("final_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
